usb_rx_line_decoder: RTL and testbench

Receive line decoder that sits directly upstream of the receive control state machine. It samples the synchronized D+/D- line state once per bit time, performs NRZI decoding, SYNC detection, bit unstuffing, byte assembly and EOP detection. It produces the byte stream and the RXActive/RXValid/RXError/SYNC/EOP status flags that the receive control FSM consumes.

---
 rtl/usb_rx_line_decoder_if.sv | 23 ++
 rtl/usb_rx_line_decoder.sv | 180 ++++++++++++++++++
 tb/tb_usb_rx_line_decoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_line_decoder_if.sv
// Line-side sample inputs and decoded byte/status outputs of the USB receive line decoder.
// The master drives the line samples, and the slave is the decoder.
interface usb_rx_line_decoder_if;
   logic       dp;
   logic       dm;
   logic       sample_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_active;
   logic       rx_error;
   logic       sync_detected;
   logic       eop_detected;

   modport master (
      output dp, dm, sample_en,
      input  rx_data, rx_valid, rx_active, rx_error, sync_detected, eop_detected
   );

   modport slave (
      input  dp, dm, sample_en,
      output rx_data, rx_valid, rx_active, rx_error, sync_detected, eop_detected
   );
endinterface

// File: rtl/usb_rx_line_decoder.sv
// USB receive line decoder: NRZI decode, SYNC hunt, bit unstuffing, byte assembly and EOP
// detection, consuming one line sample per sample_en strobe.
module usb_rx_line_decoder #(
   parameter int unsigned IDLE_J_BITS  = 7,
   parameter int unsigned SYNC_TIMEOUT = 16
) (
   input logic                  clk,
   input logic                  nRST,
   usb_rx_line_decoder_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StSyncHunt, StData, StEop, StErrWait} state_t;

   localparam logic [7:0] SyncLast  = 8'(SYNC_TIMEOUT - 1);
   localparam logic [7:0] IdleJLast = 8'(IDLE_J_BITS - 1);

   state_t     state;
   logic       prev_j;
   logic [7:0] sync_hist;
   logic [7:0] hunt_cnt;
   logic [2:0] bit_cnt;
   logic [2:0] ones_cnt;
   logic [7:0] shreg;
   logic [2:0] se0_cnt;
   logic       misaligned;
   logic [7:0] j_cnt;
   logic       err_se0;

   logic [7:0] rx_data_reg;
   logic       rx_valid_reg;
   logic       rx_active_reg;
   logic       rx_error_reg;
   logic       sync_reg;
   logic       eop_reg;

   logic       sym_j;
   logic       sym_k;
   logic       sym_se0;
   logic       sym_se1;
   logic       nrzi_bit;
   logic [7:0] hist_next;
   logic [7:0] shreg_next;

   assign sym_j      = bus.dp & ~bus.dm;
   assign sym_k      = ~bus.dp & bus.dm;
   assign sym_se0    = ~bus.dp & ~bus.dm;
   assign sym_se1    = bus.dp & bus.dm;
   assign nrzi_bit   = ~(sym_j ^ prev_j);
   assign hist_next  = {sync_hist[6:0], nrzi_bit};
   assign shreg_next = {nrzi_bit, shreg[7:1]};

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state         <= StIdle;
         prev_j        <= 1'b1;
         sync_hist     <= '0;
         hunt_cnt      <= '0;
         bit_cnt       <= '0;
         ones_cnt      <= '0;
         shreg         <= '0;
         se0_cnt       <= '0;
         misaligned    <= 1'b0;
         j_cnt         <= '0;
         err_se0       <= 1'b0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         rx_active_reg <= 1'b0;
         rx_error_reg  <= 1'b0;
         sync_reg      <= 1'b0;
         eop_reg       <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         rx_error_reg <= 1'b0;
         sync_reg     <= 1'b0;
         eop_reg      <= 1'b0;
         if (bus.sample_en) begin
            if (sym_j | sym_k) begin
               prev_j <= sym_j;
            end
            // Recovery counters start from zero on every entry into StErrWait.
            if (state != StErrWait) begin
               j_cnt   <= '0;
               err_se0 <= 1'b0;
            end
            case (state)
               StIdle: begin
                  if (sym_k) begin
                     // Padding with ones keeps the pattern from matching before 8 real bits.
                     sync_hist <= {7'h7f, nrzi_bit};
                     hunt_cnt  <= 8'd1;
                     state     <= StSyncHunt;
                  end
               end
               StSyncHunt: begin
                  if (sym_j | sym_k) begin
                     sync_hist <= hist_next;
                     hunt_cnt  <= hunt_cnt + 8'd1;
                     if (hist_next == 8'h01) begin
                        sync_reg      <= 1'b1;
                        rx_active_reg <= 1'b1;
                        bit_cnt       <= '0;
                        ones_cnt      <= 3'd1;
                        state         <= StData;
                     end else if (hunt_cnt == SyncLast) begin
                        state <= StIdle;
                     end
                  end else begin
                     state <= StIdle;
                  end
               end
               StData: begin
                  if (sym_se0) begin
                     se0_cnt    <= 3'd1;
                     misaligned <= (bit_cnt != 3'd0);
                     state      <= StEop;
                  end else if (sym_se1) begin
                     rx_error_reg <= 1'b1;
                     state        <= StErrWait;
                  end else if (ones_cnt == 3'd6) begin
                     if (nrzi_bit) begin
                        rx_error_reg <= 1'b1;
                        state        <= StErrWait;
                     end else begin
                        ones_cnt <= '0;
                     end
                  end else begin
                     ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                     shreg    <= shreg_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rx_data_reg  <= shreg_next;
                        rx_valid_reg <= 1'b1;
                     end
                  end
               end
               StEop: begin
                  if (sym_se0) begin
                     if (se0_cnt == 3'd3) begin
                        rx_error_reg <= 1'b1;
                        state        <= StErrWait;
                     end else begin
                        se0_cnt <= se0_cnt + 3'd1;
                     end
                  end else if (sym_j) begin
                     eop_reg       <= 1'b1;
                     rx_error_reg  <= misaligned;
                     rx_active_reg <= 1'b0;
                     state         <= StIdle;
                  end else begin
                     rx_error_reg <= 1'b1;
                     state        <= StErrWait;
                  end
               end
               StErrWait: begin
                  if (sym_j) begin
                     err_se0 <= 1'b0;
                     j_cnt   <= j_cnt + 8'd1;
                     if (err_se0 || j_cnt == IdleJLast) begin
                        rx_active_reg <= 1'b0;
                        state         <= StIdle;
                     end
                  end else begin
                     j_cnt   <= '0;
                     err_se0 <= sym_se0;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

   assign bus.rx_data       = rx_data_reg;
   assign bus.rx_valid      = rx_valid_reg;
   assign bus.rx_active     = rx_active_reg;
   assign bus.rx_error      = rx_error_reg;
   assign bus.sync_detected = sync_reg;
   assign bus.eop_detected  = eop_reg;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Bench for usb_rx_line_decoder: directed packets with literal expectations plus random line
// traffic, all outputs compared every clock against a behavioural model.
module tb_usb_rx_line_decoder;

   localparam int IdleJ  = 7;
   localparam int SyncTo = 16;
   localparam logic [1:0] SymJ   = 2'b10;
   localparam logic [1:0] SymK   = 2'b01;
   localparam logic [1:0] SymSe0 = 2'b00;
   localparam logic [1:0] SymSe1 = 2'b11;
   localparam int MIdle = 0;
   localparam int MHunt = 1;
   localparam int MData = 2;
   localparam int MEop  = 3;
   localparam int MErr  = 4;

   logic clk  = 1'b0;
   logic nRST = 1'b0;
   always #5 clk = ~clk;

   usb_rx_line_decoder_if bus ();

   usb_rx_line_decoder #(
      .IDLE_J_BITS (IdleJ),
      .SYNC_TIMEOUT(SyncTo)
   ) dut (
      .clk (clk),
      .nRST(nRST),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the outputs must show after each clock.
   typedef struct {
      int       mode;
      bit       prev_j;
      int       hunt_n;
      bit [7:0] hunt_last;
      int       ones;
      int       nbits;
      bit [7:0] acc;
      int       se0_n;
      bit       mis;
      int       jrun;
      bit       err_se0;
      bit       valid;
      bit       err;
      bit       sync;
      bit       eop;
      bit       active;
      bit [7:0] data;
   } mdl_t;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.mode = MIdle; m.prev_j = 1'b1; m.hunt_n = 0; m.hunt_last = 8'd0;
      m.ones = 0; m.nbits = 0; m.acc = 8'd0; m.se0_n = 0; m.mis = 1'b0;
      m.jrun = 0; m.err_se0 = 1'b0; m.valid = 1'b0; m.err = 1'b0; m.sync = 1'b0;
      m.eop = 1'b0; m.active = 1'b0; m.data = 8'd0;
      return m;
   endfunction

   function automatic mdl_t to_err(mdl_t m);
      m.err = 1'b1; m.mode = MErr; m.jrun = 0; m.err_se0 = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, bit [1:0] s, bit en);
      bit is_j;
      bit is_k;
      bit b;
      m.valid = 1'b0; m.err = 1'b0; m.sync = 1'b0; m.eop = 1'b0;
      if (!en) return m;
      is_j = (s == SymJ);
      is_k = (s == SymK);
      b = 1'b0;
      if (is_j || is_k) begin
         b = (is_j == m.prev_j);
         m.prev_j = is_j;
      end
      case (m.mode)
         MIdle: if (is_k) begin
            m.mode = MHunt; m.hunt_n = 1; m.hunt_last = {7'd0, b};
         end
         MHunt: if (!(is_j || is_k)) m.mode = MIdle;
         else begin
            m.hunt_n++;
            m.hunt_last = {m.hunt_last[6:0], b};
            if (m.hunt_n >= 8 && m.hunt_last == 8'h01) begin
               m.sync = 1'b1; m.active = 1'b1; m.mode = MData;
               m.ones = 1; m.nbits = 0; m.acc = 8'd0;
            end else if (m.hunt_n >= SyncTo) m.mode = MIdle;
         end
         MData: if (s == SymSe0) begin
            m.mode = MEop; m.se0_n = 1; m.mis = (m.nbits != 0);
         end else if (s == SymSe1) m = to_err(m);
         else if (m.ones == 6) begin
            if (b) m = to_err(m);
            else m.ones = 0;
         end else begin
            m.ones = b ? m.ones + 1 : 0;
            m.acc = m.acc | (8'(b) << m.nbits);
            m.nbits++;
            if (m.nbits == 8) begin
               m.data = m.acc; m.valid = 1'b1; m.nbits = 0; m.acc = 8'd0;
            end
         end
         MEop: if (s == SymSe0) begin
            m.se0_n++;
            if (m.se0_n == 4) m = to_err(m);
         end else if (is_j) begin
            m.eop = 1'b1; m.err = m.mis; m.active = 1'b0; m.mode = MIdle;
         end else m = to_err(m);
         default: if (is_j) begin
            m.jrun++;
            if (m.err_se0 || m.jrun == IdleJ) begin
               m.active = 1'b0; m.mode = MIdle;
            end
            m.err_se0 = 1'b0;
         end else begin
            m.jrun = 0; m.err_se0 = (s == SymSe0);
         end
      endcase
      return m;
   endfunction

   mdl_t m;
   always @(posedge clk or negedge nRST) begin
      if (!nRST) m <= mdl_reset();
      else m <= mdl_step(m, {bus.dp, bus.dm}, bus.sample_en);
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("rx_valid", int'(bus.rx_valid), int'(m.valid));
         chk("rx_error", int'(bus.rx_error), int'(m.err));
         chk("sync_detected", int'(bus.sync_detected), int'(m.sync));
         chk("eop_detected", int'(bus.eop_detected), int'(m.eop));
         chk("rx_active", int'(bus.rx_active), int'(m.active));
         chk("rx_data", int'(bus.rx_data), int'(m.data));
      end
   end

   // Event log for the directed literal expectations.
   logic [7:0] got[$];
   logic [7:0] want[$];
   int n_sync, n_eop, n_err, n_both;

   initial forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) got.push_back(bus.rx_data);
      if (bus.sync_detected === 1'b1) n_sync++;
      if (bus.eop_detected === 1'b1) n_eop++;
      if (bus.rx_error === 1'b1) n_err++;
      if (bus.rx_error === 1'b1 && bus.eop_detected === 1'b1) n_both++;
   end

   task automatic clear_log();
      got.delete(); want.delete();
      n_sync = 0; n_eop = 0; n_err = 0; n_both = 0;
   endtask

   task automatic chk_log(input string name, input int e_sync, input int e_eop, input int e_err);
      chk({name, "_nbytes"}, got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++)
         chk({name, "_byte"}, int'(got[i]), int'(want[i]));
      chk({name, "_nsync"}, n_sync, e_sync);
      chk({name, "_neop"}, n_eop, e_eop);
      chk({name, "_nerr"}, n_err, e_err);
   endtask

   // Line driver: one strobe per symbol, then a random gap with junk on the line.
   int min_gap = 0;
   int max_gap = 0;
   bit line_j = 1'b1;
   int tx_ones = 0;

   task automatic send_sym(input logic [1:0] s);
      int gap;
      bus.dp = s[1];
      bus.dm = s[0];
      bus.sample_en = 1'b1;
      if (s == SymJ) line_j = 1'b1;
      else if (s == SymK) line_j = 1'b0;
      @(negedge clk);
      bus.sample_en = 1'b0;
      gap = int'($urandom_range(max_gap, min_gap));
      repeat (gap) begin
         {bus.dp, bus.dm} = 2'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) send_sym(SymJ);
   endtask

   task automatic send_bit(input bit b);
      send_sym(((b && line_j) || (!b && !line_j)) ? SymJ : SymK);
   endtask

   task automatic send_data_bit(input bit b);
      send_bit(b);
      tx_ones = b ? tx_ones + 1 : 0;
      if (tx_ones == 6) begin
         send_bit(1'b0);
         tx_ones = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_data_bit(v[i]);
   endtask

   task automatic send_sync();
      repeat (7) send_bit(1'b0);
      send_bit(1'b1);
      tx_ones = 1;
   endtask

   task automatic send_eop();
      send_sym(SymSe0);
      send_sym(SymSe0);
      send_sym(SymJ);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_valid"}, int'(bus.rx_valid), 0);
      chk({name, "_active"}, int'(bus.rx_active), 0);
      chk({name, "_error"}, int'(bus.rx_error), 0);
      chk({name, "_sync"}, int'(bus.sync_detected), 0);
      chk({name, "_eop"}, int'(bus.eop_detected), 0);
      chk({name, "_data"}, int'(bus.rx_data), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      int r;
      bus.dp = 1'b1; bus.dm = 1'b0; bus.sample_en = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      nRST = 1'b1;
      idle(3);

      clear_log();
      send_sync(); send_byte(8'hA5); send_eop(); idle(2);
      want.push_back(8'hA5);
      chk_log("good", 1, 1, 0);
      chk("good_data_held", int'(bus.rx_data), 'hA5);

      clear_log();
      idle(1); send_sync(); send_byte(8'h3F); send_byte(8'h01); send_eop(); idle(2);
      want.push_back(8'h3F); want.push_back(8'h01);
      chk_log("stuffing", 1, 1, 0);

      clear_log();
      send_sync();
      repeat (6) send_bit(1'b1);
      chk("stuff_err_pulse", int'(bus.rx_error), 1);
      chk("stuff_err_active", int'(bus.rx_active), 1);
      idle(6);
      chk("stuff_err_active_6j", int'(bus.rx_active), 1);
      idle(1);
      chk("stuff_err_active_7j", int'(bus.rx_active), 0);
      idle(1);
      chk_log("stuff_err", 1, 0, 1);

      clear_log();
      send_sync(); send_byte(8'h12);
      send_data_bit(1'b0); send_data_bit(1'b1); send_data_bit(1'b0);
      send_eop(); idle(2);
      want.push_back(8'h12);
      chk_log("misalign", 1, 1, 1);
      chk("misalign_coincide", n_both, 1);

      clear_log();
      send_sync(); send_byte(8'h80);
      repeat (4) send_sym(SymSe0);
      chk("long_se0_err", int'(bus.rx_error), 1);
      idle(8);
      chk("long_se0_recovered", int'(bus.rx_active), 0);
      want.push_back(8'h80);
      chk_log("long_se0", 1, 0, 1);

      clear_log();
      send_sync();
      send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
      send_sym(SymSe1);
      chk("se1_err", int'(bus.rx_error), 1);
      idle(8);
      chk_log("se1", 1, 0, 1);

      clear_log();
      repeat (SyncTo) send_sym(SymK);
      idle(4);
      chk("timeout_active", int'(bus.rx_active), 0);
      chk_log("timeout", 0, 0, 0);

      clear_log();
      send_sync(); send_byte(8'hA5); send_eop();
      send_sync(); send_byte(8'h3C); send_eop(); idle(2);
      want.push_back(8'hA5); want.push_back(8'h3C);
      chk_log("back2back", 2, 2, 0);

      min_gap = 1; max_gap = 5;
      clear_log();
      idle(2); send_sync(); send_byte(8'hA5); send_eop(); idle(2);
      want.push_back(8'hA5);
      chk_log("gaps", 1, 1, 0);
      min_gap = 0; max_gap = 0;

      idle(2); send_sync();
      send_data_bit(1'b1); send_data_bit(1'b1); send_data_bit(1'b0);
      chk("pre_reset_active", int'(bus.rx_active), 1);
      #2 nRST = 1'b0;
      #1 chk_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      nRST = 1'b1;
      clear_log();
      idle(2); send_sync(); send_byte(8'h5A); send_eop(); idle(2);
      want.push_back(8'h5A);
      chk_log("after_reset", 1, 1, 0);

      for (int it = 0; it < 150; it++) begin
         max_gap = int'($urandom_range(2, 0));
         if ($urandom_range(3, 0) != 0) begin
            idle(int'($urandom_range(2, 0)));
            send_sync();
            nb = int'($urandom_range(4, 1));
            repeat (nb) send_byte(8'($urandom));
            if ($urandom_range(3, 0) == 0)
               repeat ($urandom_range(7, 1)) send_data_bit(1'($urandom));
            r = int'($urandom_range(5, 0));
            if (r == 0) send_sym(SymSe1);
            else if (r == 1) repeat (4) send_sym(SymSe0);
            else send_eop();
         end else begin
            nb = int'($urandom_range(30, 5));
            repeat (nb) begin
               r = int'($urandom_range(19, 0));
               send_sym(r < 8 ? SymJ : (r < 16 ? SymK : (r < 19 ? SymSe0 : SymSe1)));
            end
            idle(24);
         end
      end
      idle(24);
      chk("final_idle", int'(bus.rx_active), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
